// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Purpose: Shared definitions for the load/store unit: access-size codes,
//          FSM state encoding and the misalignment rule.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also treated as word

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Half must be 2-byte aligned, word (size 1x) must be 4-byte aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    r = 1'b0;
    if (size[1])
      r = (off != 2'b00);
    else if (size == SZ_HALF)
      r = off[0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module : load_store_unit_if
// Purpose: Bundles the request/response handshake and the DataMemory port.
//          slave  : the load/store unit's view
//          master : the environment's view (requester plus DataMemory)
// Signals: Req/Wr/Size/SignExt/Addr/StoreData   request
//          Ready/Done/MisalignErr/LoadData        response
//          MemAddress/MemWriteData/MemWrite/MemRead/MemReadData  memory port
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              Req;
  logic              Wr;
  logic [1:0]        Size;
  logic              SignExt;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       StoreData;
  logic              Ready;
  logic              Done;
  logic              MisalignErr;
  logic [31:0]       LoadData;
  logic [ADDR_W-1:0] MemAddress;
  logic [31:0]       MemWriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [31:0]       MemReadData;

  modport slave (
    input  Req, Wr, Size, SignExt, Addr, StoreData, MemReadData,
    output Ready, Done, MisalignErr, LoadData, MemAddress, MemWriteData, MemWrite, MemRead
  );

  modport master (
    output Req, Wr, Size, SignExt, Addr, StoreData, MemReadData,
    input  Ready, Done, MisalignErr, LoadData, MemAddress, MemWriteData, MemWrite, MemRead
  );
endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module : lsu_lane_align
// Purpose: Combinational little-endian lane logic shared by the load path
//          (extract + extend) and the sub-word store read-modify-write path.
// Ports  : i_word    memory word (read data)
//          i_off     byte offset Addr[1:0]
//          i_size    access size code
//          i_sext    1 = sign-extend on extract
//          i_data    store data, right-justified (low 16 bits used)
//          o_extract selected lane, extended to 32 bits
//          o_merge   i_word with the addressed lane replaced by i_data
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  wire logic [DATA_W-1:0] i_word,
  input  wire logic [1:0]        i_off,
  input  wire logic [1:0]        i_size,
  input  wire logic              i_sext,
  input  wire logic [15:0]       i_data,
  output logic      [DATA_W-1:0] o_extract,
  output logic      [DATA_W-1:0] o_merge
);

  logic [4:0]        w_bsh;   // bit shift of the addressed byte lane
  logic [4:0]        w_hsh;   // bit shift of the addressed half lane
  logic [DATA_W-1:0] w_bshifted;
  logic [DATA_W-1:0] w_hshifted;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_bsh      = {i_off, 3'b000};
  assign w_hsh      = {i_off[1], 4'b0000};
  assign w_bshifted = i_word >> w_bsh;
  assign w_hshifted = i_word >> w_hsh;
  assign w_byte     = w_bshifted[7:0];
  assign w_half     = w_hshifted[15:0];

  always_comb begin
    o_extract = i_word;
    o_merge   = i_word;
    if (!i_size[1]) begin
      if (i_size == SZ_HALF) begin
        o_extract = {{16{i_sext & w_half[15]}}, w_half};
        o_merge   = (i_word & ~(32'h0000_FFFF << w_hsh)) | ({16'h0, i_data} << w_hsh);
      end else begin
        o_extract = {{24{i_sext & w_byte[7]}}, w_byte};
        o_merge   = (i_word & ~(32'h0000_00FF << w_bsh)) | ({24'h0, i_data[7:0]} << w_bsh);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Purpose: MEM-stage initiator for a word-wide DataMemory. Executes byte,
//          half and word loads/stores with a Req/Ready/Done handshake;
//          sub-word stores are read-modify-write; misaligned accesses are
//          reported and never reach memory.
// Ports  : i_clk  clock (posedge)
//          i_rst  asynchronous active-high reset
//          bus    load_store_unit_if.slave (request, response, memory port)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  load_store_unit_if.slave bus
);

  state_t              r_state;
  logic                r_wr;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [1:0]          r_off;
  logic [15:0]         r_sdata;
  logic                r_done;
  logic                r_misalign;
  logic [DATA_W-1:0]   r_load_data;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_write;
  logic                r_mem_read;
  logic [DATA_W-1:0]   w_extract;
  logic [DATA_W-1:0]   w_merge;

  lsu_lane_align u_align (
    .i_word    (bus.MemReadData),
    .i_off     (r_off),
    .i_size    (r_size),
    .i_sext    (r_sext),
    .i_data    (r_sdata),
    .o_extract (w_extract),
    .o_merge   (w_merge)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_sext      <= 1'b0;
      r_off       <= 2'b00;
      r_sdata     <= '0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_load_data <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else begin
      // Pulses and enables default low; each state raises what it owns.
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Ready is high whenever we are here out of reset.
          if (bus.Req) begin
            r_wr    <= bus.Wr;
            r_size  <= bus.Size;
            r_sext  <= bus.SignExt;
            r_off   <= bus.Addr[1:0];
            r_sdata <= bus.StoreData[15:0];
            if (misaligned(bus.Size, bus.Addr[1:0])) begin
              r_state    <= S_RESP;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
              if (!bus.Wr)
                r_load_data <= '0;
            end else if (bus.Wr && bus.Size[1]) begin
              r_state     <= S_WR;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {bus.Addr[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= bus.StoreData;
            end else begin
              // Loads and sub-word stores both start by reading the word.
              r_state    <= S_RD;
              r_mem_read <= 1'b1;
              r_mem_addr <= {bus.Addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        S_RD: begin
          if (r_wr) begin
            r_state     <= S_WR;
            r_mem_write <= 1'b1;
            r_mem_wdata <= w_merge;
          end else begin
            r_state     <= S_RESP;
            r_done      <= 1'b1;
            r_load_data <= w_extract;
            r_mem_addr  <= '0;
          end
        end
        S_WR: begin
          r_state     <= S_RESP;
          r_done      <= 1'b1;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Ready        = (r_state == S_IDLE) && !i_rst;
  assign bus.Done         = r_done;
  assign bus.MisalignErr  = r_misalign;
  assign bus.LoadData     = r_load_data;
  assign bus.MemAddress   = r_mem_addr;
  assign bus.MemWriteData = r_mem_wdata;
  assign bus.MemWrite     = r_mem_write;
  assign bus.MemRead      = r_mem_read;

endmodule

`default_nettype wire
